frame_dispatcher: RTL and testbench
===================================

FRAME_DISPATCHER -- requirements
Module: frame_dispatcher

Interface
REQ-001 Parameter D_WIDTH, default 8, character width in bits.
REQ-002 Parameter MAX_NOF_CHARS, default 50, maximum characters forwarded per frame.
REQ-003 Parameter START_DECRYPTION_TOKEN, default 8'hFA, end-of-frame / start-decryption character.
REQ-004 Parameter START_TIMEOUT, default 4, cycles allowed for the selected decryptor to raise busy.
REQ-005 Port clk  input  1  system clock; one clock, all logic on rising edge.
REQ-006 Port rst  input  1  reset, synchronous, active-high.
REQ-007 Port data_i  input  D_WIDTH  incoming character or token.
REQ-008 Port valid_i  input  1  data_i qualifier.
REQ-009 Port sel_i  input  2  cipher select: 0 caesar, 1 scytale, 2 zigzag, 3 invalid.
REQ-010 Port busy_i  input  3  busy flags of the three decryptors, bit index = sel code.
REQ-011 Port ready_o  output  1  high when a character is accepted this cycle.
REQ-012 Port data_o  output  D_WIDTH  character bus shared by all decryptors.
REQ-013 Port valid_o  output  3  one-hot qualifier for data_o, bit = destination decryptor.
REQ-014 Port frame_len_o  output  8  characters forwarded in the current/last frame, token excluded.
REQ-015 Port overflow_o  output  1  sticky: a frame exceeded MAX_NOF_CHARS.
REQ-016 Port drop_o  output  1  one-cycle pulse for each character discarded.

Function
REQ-017 States SHALL be IDLE, FWD, WAIT_START, WAIT_DONE.
REQ-018 ready_o SHALL be 1 in IDLE and FWD, 0 in WAIT_START and WAIT_DONE.
REQ-019 Accept = valid_i and ready_o; any valid_i with ready_o=0 SHALL pulse drop_o next cycle, nothing forwarded.
REQ-020 IDLE, accept of non-token with sel_i in 0..2: latch sel_i as channel, forward, frame_len_o=1, go FWD.
REQ-021 IDLE, accept with sel_i=3: discard, pulse drop_o, stay IDLE; frame_len_o unchanged.
REQ-022 IDLE, accept of token (empty frame): discard, pulse drop_o, stay IDLE.
REQ-023 Forwarding latency SHALL be one cycle: data_o=data_i and valid_o=one-hot(channel) in the cycle after accept.
REQ-024 valid_o SHALL be 0 and data_o SHALL hold its last value in every cycle not forwarding.
REQ-025 FWD: sel_i ignored; latched channel used for whole frame.
REQ-026 FWD, accept of non-token with frame_len_o < MAX_NOF_CHARS: forward, increment frame_len_o.
REQ-027 FWD, accept of non-token with frame_len_o = MAX_NOF_CHARS: discard, pulse drop_o, set overflow_o.
REQ-028 FWD, accept of token: forward token to channel, go WAIT_START, clear timeout counter.
REQ-029 WAIT_START: when busy_i[channel]=1 go WAIT_DONE; after START_TIMEOUT cycles without it go IDLE.
REQ-030 WAIT_DONE: when busy_i[channel]=0 go IDLE; ready_o high from the following cycle.
REQ-031 busy_i bits of non-selected channels SHALL be ignored in all states.
REQ-032 frame_len_o SHALL saturate at MAX_NOF_CHARS and hold after frame end until next frame starts.
REQ-033 overflow_o SHALL clear only on reset.

Reset
REQ-034 rst=1 SHALL force IDLE, valid_o=0, data_o=0, frame_len_o=0, overflow_o=0, drop_o=0, ready_o=1 next cycle.
REQ-035 rst SHALL take priority over valid_i in the same cycle; the character is neither forwarded nor counted as dropped.
REQ-036 rst mid-frame SHALL abandon the frame; no token is generated toward the decryptor.

Verification
REQ-037 sel_i=2, chars 'A','B','C' then 8'hFA on consecutive cycles -> valid_o=3'b100 for 4 cycles with data A,B,C,FA one cycle delayed; ready_o=0 after FA until busy_i[2] falls.
REQ-038 sel_i=0 at frame start, switched to 1 mid-frame -> all chars on valid_o=3'b001; frame_len_o equals char count.
REQ-039 51 chars then token with MAX_NOF_CHARS=50 -> 50 forwarded, one drop_o pulse, overflow_o=1, token forwarded, frame_len_o=50.
REQ-040 Token forwarded, busy_i[channel] never rises -> ready_o returns 1 after 4 cycles in WAIT_START; char during wait -> drop_o pulse.
REQ-041 sel_i=3 char, then lone token in IDLE -> two drop_o pulses, valid_o stays 0.
REQ-042 rst asserted after 3 forwarded chars -> next cycle all outputs at reset values, following char starts a new frame with frame_len_o=1.

Source files
------------

// File: rtl/frame_dispatcher.sv
// frame_dispatcher
//   Collects characters into frames and forwards them to one of three
//   decryptors (caesar, scytale, zigzag). The decryptor is chosen by sel_i on
//   the first character of a frame. A frame ends with START_DECRYPTION_TOKEN,
//   which is also forwarded. The dispatcher then waits for the selected
//   decryptor to raise busy and drop it again before it accepts a new frame.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous reset, active high
//   data_i       incoming character or token
//   valid_i      data_i qualifier
//   sel_i        cipher select: 0 caesar, 1 scytale, 2 zigzag, 3 invalid
//   busy_i       busy flags of the decryptors, bit index = sel code
//   ready_o      character accepted this cycle
//   data_o       character bus shared by all decryptors
//   valid_o      one-hot qualifier for data_o, bit = destination decryptor
//   frame_len_o  characters forwarded in current/last frame, token excluded
//   overflow_o   sticky: a frame exceeded MAX_NOF_CHARS
//   drop_o       one-cycle pulse per discarded character
module frame_dispatcher #(
  parameter int                 D_WIDTH                = 8,
  parameter int                 MAX_NOF_CHARS          = 50,
  parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = 8'hFA,
  parameter int                 START_TIMEOUT          = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] data_i,
  input  logic               valid_i,
  input  logic [1:0]         sel_i,
  input  logic [2:0]         busy_i,
  output logic               ready_o,
  output logic [D_WIDTH-1:0] data_o,
  output logic [2:0]         valid_o,
  output logic [7:0]         frame_len_o,
  output logic               overflow_o,
  output logic               drop_o
);

  localparam int             TO_W    = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(START_TIMEOUT - 1);
  localparam logic [7:0]     MAX_LEN = 8'(MAX_NOF_CHARS);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FWD        = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } state_t;

  state_t             state;
  logic [1:0]         chan;
  logic [TO_W-1:0]    to_cnt;
  logic [7:0]         len_p1;
  logic               ovf_p1;
  logic               drop_p1;
  logic [D_WIDTH-1:0] data_p1;
  logic [2:0]         vld_p1;

  logic               accept_p0;
  logic               is_token_p0;

  // Frame length never exceeds MAX_NOF_CHARS.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v >= MAX_LEN) ? MAX_LEN : v + 8'd1;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] s);
    return 3'b001 << s;
  endfunction

  // Stage p0: input qualification
  assign ready_o     = (state == IDLE) || (state == FWD);
  assign accept_p0   = valid_i && ready_o;
  assign is_token_p0 = (data_i == START_DECRYPTION_TOKEN);

  // Stage p1: registered forwarding, status and FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      chan    <= 2'd0;
      to_cnt  <= '0;
      len_p1  <= 8'd0;
      ovf_p1  <= 1'b0;
      drop_p1 <= 1'b0;
      data_p1 <= '0;
      vld_p1  <= 3'b000;
    end else begin
      vld_p1  <= 3'b000;
      // A character offered while not ready is lost.
      drop_p1 <= valid_i && !ready_o;

      case (state)
        IDLE: begin
          if (accept_p0) begin
            if (sel_i == 2'd3 || is_token_p0) begin
              drop_p1 <= 1'b1;
            end else begin
              chan    <= sel_i;
              data_p1 <= data_i;
              vld_p1  <= onehot(sel_i);
              len_p1  <= 8'd1;
              state   <= FWD;
            end
          end
        end

        FWD: begin
          if (accept_p0) begin
            if (is_token_p0) begin
              data_p1 <= data_i;
              vld_p1  <= onehot(chan);
              to_cnt  <= '0;
              state   <= WAIT_START;
            end else if (len_p1 < MAX_LEN) begin
              data_p1 <= data_i;
              vld_p1  <= onehot(chan);
              len_p1  <= sat_inc(len_p1);
            end else begin
              drop_p1 <= 1'b1;
              ovf_p1  <= 1'b1;
            end
          end
        end

        WAIT_START: begin
          // Give up after START_TIMEOUT cycles without busy from the channel.
          if (busy_i[chan]) begin
            state <= WAIT_DONE;
          end else if (to_cnt == TO_LAST) begin
            state <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        WAIT_DONE: begin
          if (!busy_i[chan]) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign data_o      = data_p1;
  assign valid_o     = vld_p1;
  assign frame_len_o = len_p1;
  assign overflow_o  = ovf_p1;
  assign drop_o      = drop_p1;

endmodule

// File: tb/tb_frame_dispatcher.sv
module tb_frame_dispatcher;

  localparam int         DW   = 8;
  localparam int         MAXC = 50;
  localparam int         TO   = 4;
  localparam logic [7:0] TOK  = 8'hFA;

  logic          clk;
  logic          rst;
  logic [DW-1:0] data_i;
  logic          valid_i;
  logic [1:0]    sel_i;
  logic [2:0]    busy_i;
  logic          ready_o;
  logic [DW-1:0] data_o;
  logic [2:0]    valid_o;
  logic [7:0]    frame_len_o;
  logic          overflow_o;
  logic          drop_o;

  frame_dispatcher #(
    .D_WIDTH               (DW),
    .MAX_NOF_CHARS         (MAXC),
    .START_DECRYPTION_TOKEN(TOK),
    .START_TIMEOUT         (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .sel_i      (sel_i),
    .busy_i     (busy_i),
    .ready_o    (ready_o),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .frame_len_o(frame_len_o),
    .overflow_o (overflow_o),
    .drop_o     (drop_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ready;
    logic [7:0] len;
    logic       ovf;
    logic       drop;
    logic [7:0] data;
    logic [2:0] vld;
  } status_t;

  typedef struct {
    logic [7:0] d;
    logic [2:0] v;
  } fwd_t;

  status_t st_q[$];
  fwd_t    fwd_q[$];
  int      total = 0;
  int      bad   = 0;

  // Reference model: frame-level view of the dispatcher.
  bit         m_in_frame  = 0;
  bit         m_wait_done = 0;
  int         m_wait_left = 0;
  int         m_ch        = 0;
  int         m_len       = 0;
  bit         m_ovf       = 0;
  logic [7:0] m_data      = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic bit m_ready();
    return !(m_wait_left > 0 || m_wait_done);
  endfunction

  // Apply one cycle of stimulus and record what the next clock edge must produce.
  task automatic drive(input bit r, input bit v, input logic [7:0] d,
                       input logic [1:0] s, input logic [2:0] b);
    status_t    e;
    fwd_t       f;
    bit         fw;
    bit         dr;
    logic [2:0] ev;
    @(negedge clk);
    rst = r; valid_i = v; data_i = d; sel_i = s; busy_i = b;
    fw = 0; dr = 0; ev = 3'b000;
    if (r) begin
      m_in_frame = 0; m_wait_done = 0; m_wait_left = 0;
      m_len = 0; m_ovf = 0; m_data = 8'h00;
    end else begin
      if (v && !m_ready()) dr = 1;
      if (m_wait_left > 0) begin
        if (b[m_ch]) begin
          m_wait_left = 0;
          m_wait_done = 1;
        end else begin
          m_wait_left--;
        end
      end else if (m_wait_done) begin
        if (!b[m_ch]) m_wait_done = 0;
      end else if (v) begin
        if (!m_in_frame) begin
          if (s == 2'd3 || d == TOK) dr = 1;
          else begin
            m_ch = int'(s); m_in_frame = 1; m_len = 1; fw = 1;
          end
        end else if (d == TOK) begin
          fw = 1; m_in_frame = 0; m_wait_left = TO;
        end else if (m_len < MAXC) begin
          fw = 1; m_len++;
        end else begin
          dr = 1; m_ovf = 1;
        end
      end
    end
    if (fw) begin
      m_data = d;
      ev = 3'b001 << m_ch;
      f.d = d; f.v = ev;
      fwd_q.push_back(f);
    end
    e.ready = m_ready();
    e.len   = 8'(m_len);
    e.ovf   = m_ovf;
    e.drop  = dr;
    e.data  = m_data;
    e.vld   = ev;
    st_q.push_back(e);
  endtask

  // Monitor: compares every observed cycle against the recorded expectations.
  initial begin : monitor
    status_t e;
    fwd_t    f;
    forever begin
      @(posedge clk);
      #1;
      if (st_q.size() > 0) begin
        e = st_q.pop_front();
        chk("ready_o",     32'(ready_o),     32'(e.ready));
        chk("frame_len_o", 32'(frame_len_o), 32'(e.len));
        chk("overflow_o",  32'(overflow_o),  32'(e.ovf));
        chk("drop_o",      32'(drop_o),      32'(e.drop));
        chk("data_o_hold", 32'(data_o),      32'(e.data));
        chk("valid_o",     32'(valid_o),     32'(e.vld));
      end
      if (valid_o !== 3'b000) begin
        if (fwd_q.size() == 0) begin
          chk("unexpected_forward", 32'(valid_o), 32'd0);
        end else begin
          f = fwd_q.pop_front();
          chk("fwd_data",    32'(data_o),  32'(f.d));
          chk("fwd_channel", 32'(valid_o), 32'(f.v));
        end
      end
    end
  end

  initial begin : stim
    bit         r;
    bit         v;
    logic [7:0] d;
    rst = 1'b1; valid_i = 1'b0; data_i = 8'h00; sel_i = 2'd0; busy_i = 3'b000;

    // Reset, including a character offered while reset is high.
    drive(1, 0, 8'h00, 0, 3'b000);
    drive(1, 1, 8'h41, 0, 3'b000);
    drive(1, 0, 8'h00, 0, 3'b000);

    // Zigzag frame A,B,C + token; other busy bits toggling; char dropped during wait.
    drive(0, 1, 8'h41, 2, 3'b000);
    drive(0, 1, 8'h42, 2, 3'b011);
    drive(0, 1, 8'h43, 2, 3'b000);
    drive(0, 1, TOK,   2, 3'b000);
    drive(0, 1, 8'h11, 0, 3'b011);
    drive(0, 0, 8'h00, 0, 3'b100);
    drive(0, 1, 8'h12, 1, 3'b111);
    drive(0, 0, 8'h00, 0, 3'b100);
    drive(0, 0, 8'h00, 0, 3'b000);
    drive(0, 0, 8'h00, 0, 3'b000);

    // Channel latched at frame start; sel_i changes mid-frame; start timeout.
    drive(0, 1, 8'h30, 0, 3'b000);
    for (int i = 1; i < 6; i++) drive(0, 1, 8'(8'h30 + i), 1, 3'b010);
    drive(0, 1, TOK, 1, 3'b000);
    for (int i = 0; i < TO; i++) drive(0, (i == 1), 8'h77, 0, 3'b110);
    drive(0, 0, 8'h00, 0, 3'b000);

    // Overflow: 51 characters then token on scytale.
    for (int i = 0; i < 51; i++) drive(0, 1, 8'(i + 1), 1, 3'b000);
    drive(0, 1, TOK, 3, 3'b000);
    drive(0, 0, 8'h00, 0, 3'b010);
    drive(0, 0, 8'h00, 0, 3'b010);
    drive(0, 0, 8'h00, 0, 3'b000);
    drive(0, 0, 8'h00, 0, 3'b000);

    // Invalid select and lone token in IDLE.
    drive(0, 1, 8'h55, 3, 3'b000);
    drive(0, 1, TOK,   0, 3'b000);
    drive(0, 0, 8'h00, 0, 3'b000);

    // Reset mid-frame, then a fresh frame.
    drive(0, 1, 8'h61, 0, 3'b000);
    drive(0, 1, 8'h62, 0, 3'b000);
    drive(0, 1, 8'h63, 0, 3'b000);
    drive(1, 1, 8'h64, 0, 3'b000);
    drive(0, 1, 8'h65, 2, 3'b000);
    drive(0, 1, 8'h66, 0, 3'b000);
    drive(0, 1, TOK,   0, 3'b000);
    for (int i = 0; i < TO + 1; i++) drive(0, 0, 8'h00, 0, 3'b011);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 299) == 0);
      v = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 29) == 0) ? TOK : 8'($urandom);
      drive(r, v, d, 2'($urandom_range(0, 3)), 3'($urandom));
    end

    for (int i = 0; i < 3; i++) drive(0, 0, 8'h00, 0, 3'b000);
    @(posedge clk);
    #2;
    chk("status_queue_drained", 32'(st_q.size()), 32'd0);
    chk("fwd_queue_drained",    32'(fwd_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
